knap_enum_ctrl: RTL and testbench

- Sequential driver for the combinational knapsack feasibility oracle (item-select bits in, single valid out).
- Walks every subset of N_ITEMS items, one candidate per cycle, on the oracle's select inputs.
- Samples the oracle verdict and counts feasible subsets.
- Buffers feasible selection vectors in a small FIFO for a ready/valid consumer; stalls enumeration when that FIFO is full.

---
 rtl/knap_pkg.sv | 17 +
 rtl/knap_sol_fifo.sv | 56 +++++
 rtl/knap_enum_ctrl.sv | 94 +++++++++
 tb/tb_knap_enum_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/knap_pkg.sv
// Shared types and sizing helpers for the knapsack subset enumerator.
package knap_pkg;

  localparam int N_ITEMS_DEFAULT    = 21;
  localparam int FIFO_DEPTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Occupancy needs one bit more than the pointers so that "full" is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/knap_sol_fifo.sv
// First-word-fall-through FIFO buffering feasible selection vectors.
module knap_sol_fifo
  import knap_pkg::*;
#(
  parameter int WIDTH = N_ITEMS_DEFAULT,
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign rdata   = mem[rptr];
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage carries data only; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/knap_enum_ctrl.sv
// Enumerates every item subset on the oracle select lines, counts feasible
// ones and streams them out through a small solution FIFO.
module knap_enum_ctrl
  import knap_pkg::*;
#(
  parameter int N_ITEMS    = N_ITEMS_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int CNT_W      = N_ITEMS + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [N_ITEMS-1:0]              cand,
  input  logic                            oracle_valid,
  output logic [CNT_W-1:0]                sol_count,
  output logic                            sol_valid,
  input  logic                            sol_ready,
  output logic [N_ITEMS-1:0]              sol_data,
  output logic [level_w(FIFO_DEPTH)-1:0]  fifo_level
);

  localparam logic [0:0] S_IDLE = 1'(IDLE);
  localparam logic [0:0] S_RUN  = 1'(RUN);

  logic [0:0] state;
  logic       running;
  logic       last;
  logic       full;
  logic       empty;
  logic       pop;
  logic       push_req;
  logic       stall;
  logic       push;

  assign running  = (state == S_RUN);
  assign busy     = running;
  assign last     = (cand == '1);
  assign sol_valid = ~empty;
  assign pop      = sol_valid & sol_ready;
  assign push_req = running & oracle_valid;
  assign stall    = push_req & full & ~pop;
  assign push     = push_req & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cand      <= '0;
      sol_count <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // The done cycle still belongs to the finished sweep, so start is ignored there.
          if (start && !done) begin
            state     <= S_RUN;
            cand      <= '0;
            sol_count <= '0;
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (oracle_valid) sol_count <= sol_count + CNT_W'(1);
            if (last) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              cand <= cand + N_ITEMS'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  knap_sol_fifo #(
    .WIDTH (N_ITEMS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (cand),
    .pop   (pop),
    .rdata (sol_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_knap_enum_ctrl.sv
// Directed bench for knap_enum_ctrl with a 4-item stub oracle and a 4-deep FIFO.
module tb_knap_enum_ctrl;

  localparam int NI = 4;
  localparam int FD = 4;
  localparam int CW = NI + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [NI-1:0] cand;
  logic          oracle_valid;
  logic [CW-1:0] sol_count;
  logic          sol_valid;
  logic          sol_ready = 1'b0;
  logic [NI-1:0] sol_data;
  logic [2:0]    fifo_level;

  logic [15:0]   feas = 16'h0000;

  assign oracle_valid = feas[cand];

  knap_enum_ctrl #(
    .N_ITEMS    (NI),
    .FIFO_DEPTH (FD),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .cand         (cand),
    .oracle_valid (oracle_valid),
    .sol_count    (sol_count),
    .sol_valid    (sol_valid),
    .sol_ready    (sol_ready),
    .sol_data     (sol_data),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] mask;
    int          exp_done_n;
    int          exp_busy_n;
  } vec_t;

  vec_t vecs[5];
  int   tests  = 0;
  int   failed = 0;
  int   got[$];
  int   exp_q[$];
  int   done_n, busy_n, cnt_after, n, pulses;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      failed++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One start pulse with the consumer always ready; records every popped vector.
  task automatic run_sweep(input logic [15:0] mask, output int dn, output int bn, output int ca);
    int k;
    got.delete();
    feas      = mask;
    sol_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    dn = -1;
    bn = 0;
    k  = 1;
    while (k <= 100) begin
      if (busy) bn++;
      if (sol_valid) got.push_back(int'(sol_data));
      if (done) begin
        dn = k;
        break;
      end
      tick();
      k++;
    end
    repeat (6) begin
      tick();
      if (sol_valid) got.push_back(int'(sol_data));
    end
    ca = int'(sol_count);
  endtask

  task automatic check_vec(input vec_t v);
    run_sweep(v.mask, done_n, busy_n, cnt_after);
    exp_q.delete();
    for (int i = 0; i < 16; i++) if (v.mask[i]) exp_q.push_back(i);
    check({v.name, " sol_count"}, cnt_after, exp_q.size());
    check({v.name, " done latency"}, done_n, v.exp_done_n);
    check({v.name, " busy cycles"}, busy_n, v.exp_busy_n);
    check({v.name, " streamed count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s stream[%0d]", v.name, i), got[i], exp_q[i]);
  endtask

  initial begin
    vecs[0] = '{"set_3_5_12", 16'h1028, 17, 16};
    vecs[1] = '{"none",       16'h0000, 17, 16};
    vecs[2] = '{"all_ready",  16'hFFFF, 17, 16};
    vecs[3] = '{"ends",       16'h8001, 17, 16};
    vecs[4] = '{"odd",        16'hAAAA, 17, 16};

    // Reset state
    tick();
    tick();
    check("reset cand", int'(cand), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset sol_count", int'(sol_count), 0);
    check("reset sol_valid", int'(sol_valid), 0);
    check("reset fifo_level", int'(fifo_level), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) check_vec(vecs[i]);
    check("final cand held", int'(cand), 15);

    // Backpressure: everything feasible, consumer stalled
    feas      = 16'hFFFF;
    sol_ready = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("stall cand", int'(cand), 4);
    check("stall level", int'(fifo_level), 4);
    check("stall busy", int'(busy), 1);
    check("stall sol_data", int'(sol_data), 0);
    check("stall sol_count", int'(sol_count), 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start in run ignored", int'(cand), 4);
    sol_ready = 1'b1;
    tick();
    sol_ready = 1'b0;
    check("one pop cand", int'(cand), 5);
    check("one pop level", int'(fifo_level), 4);
    check("one pop sol_data", int'(sol_data), 1);
    sol_ready = 1'b1;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check("backpressure done seen", int'(done), 1);
    check("backpressure sol_count", int'(sol_count), 16);
    repeat (6) tick();
    check("backpressure drained", int'(fifo_level), 0);

    // Asynchronous reset mid-sweep with two buffered vectors
    feas      = 16'h0024;
    sol_ready = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (cand != 4'd7 && n < 50) begin
      tick();
      n++;
    end
    check("pre-reset cand", int'(cand), 7);
    check("pre-reset level", int'(fifo_level), 2);
    #2;
    rst = 1'b1;
    #1;
    check("async rst cand", int'(cand), 0);
    check("async rst level", int'(fifo_level), 0);
    check("async rst busy", int'(busy), 0);
    check("async rst sol_count", int'(sol_count), 0);
    check("async rst sol_valid", int'(sol_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_vec(vecs[0]);

    // start held high through the whole sweep and the done cycle
    feas      = 16'h1028;
    sol_ready = 1'b1;
    start     = 1'b1;
    pulses    = 0;
    n         = 0;
    tick();
    while (!done && n < 100) begin
      tick();
      n++;
    end
    if (done) pulses++;
    tick();
    start = 1'b0;
    check("held start no restart", int'(busy), 0);
    repeat (25) begin
      tick();
      if (done) pulses++;
    end
    check("held start done pulses", pulses, 1);
    check("held start sol_count", int'(sol_count), 3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
